// File: rtl/pipe_demux.sv
// Registered 1-to-2 demux: in_sel=1 steers to A, 0 to B, each output behind a 2-entry FIFO.
// Optional delivery counters stat_a/stat_b are enabled by defining PIPE_DEMUX_STATS_EN.
module pipe_demux #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready
`ifdef PIPE_DEMUX_STATS_EN
  ,
  output logic [15:0]      stat_a,
  output logic [15:0]      stat_b
`endif
);

  localparam logic [1:0] DEPTH = 2'd2;

  logic [WIDTH-1:0] memA_q [2];
  logic [WIDTH-1:0] memB_q [2];
  logic [1:0]       cntA_q, cntA_d, cntB_q, cntB_d;
  logic             wptrA_q, rptrA_q, wptrB_q, rptrB_q;
  logic             rstDone_q;
  logic             accept, pushA, pushB, popA, popB;

  // rstDone_q holds in_ready low until the first edge after reset release.
  assign in_ready = rstDone_q && (in_sel ? (cntA_q != DEPTH) : (cntB_q != DEPTH));
  assign accept   = in_valid && in_ready;
  assign pushA    = accept && in_sel;
  assign pushB    = accept && !in_sel;

  assign out_a_valid = (cntA_q != 2'd0);
  assign out_b_valid = (cntB_q != 2'd0);
  assign out_a_data  = out_a_valid ? memA_q[rptrA_q] : '0;
  assign out_b_data  = out_b_valid ? memB_q[rptrB_q] : '0;
  assign popA        = out_a_valid && out_a_ready;
  assign popB        = out_b_valid && out_b_ready;

  always_comb begin
    cntA_d = cntA_q;
    cntB_d = cntB_q;
    if (pushA && !popA)      cntA_d = cntA_q + 2'd1;
    else if (!pushA && popA) cntA_d = cntA_q - 2'd1;
    if (pushB && !popB)      cntB_d = cntB_q + 2'd1;
    else if (!pushB && popB) cntB_d = cntB_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstDone_q <= 1'b0;
      cntA_q    <= 2'd0;
      cntB_q    <= 2'd0;
      wptrA_q   <= 1'b0;
      rptrA_q   <= 1'b0;
      wptrB_q   <= 1'b0;
      rptrB_q   <= 1'b0;
    end else begin
      rstDone_q <= 1'b1;
      cntA_q    <= cntA_d;
      cntB_q    <= cntB_d;
      if (pushA) wptrA_q <= ~wptrA_q;
      if (popA)  rptrA_q <= ~rptrA_q;
      if (pushB) wptrB_q <= ~wptrB_q;
      if (popB)  rptrB_q <= ~rptrB_q;
    end
  end

  // Storage needs no reset: an empty FIFO forces its data output to zero.
  always_ff @(posedge clk) begin
    if (pushA) memA_q[wptrA_q] <= in_data;
    if (pushB) memB_q[wptrB_q] <= in_data;
  end

`ifdef PIPE_DEMUX_STATS_EN
  logic [15:0] statA_q, statB_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statA_q <= 16'd0;
      statB_q <= 16'd0;
    end else begin
      if (popA) statA_q <= statA_q + 16'd1;
      if (popB) statB_q <= statB_q + 16'd1;
    end
  end

  assign stat_a = statA_q;
  assign stat_b = statB_q;
`endif

endmodule

// File: tb/tb_pipe_demux.sv
// Directed self-checking bench for pipe_demux: reset, routing, backpressure, push/pop, stats.
module tb_pipe_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel, in_valid, in_ready;
  logic [31:0] out_a_data, out_b_data;
  logic        out_a_valid, out_a_ready, out_b_valid, out_b_ready;
`ifdef PIPE_DEMUX_STATS_EN
  logic [15:0] stat_a, stat_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_demux #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_a_data(out_a_data), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_b_data(out_b_data), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready)
`ifdef PIPE_DEMUX_STATS_EN
    , .stat_a(stat_a), .stat_b(stat_b)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [31:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0);
    tick();
    tick();
    checkOutput("rst_a_valid", out_a_valid, 0);
    checkOutput("rst_b_valid", out_b_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_a_data", out_a_data, 0);
    checkOutput("rst_b_data", out_b_data, 0);
`ifdef PIPE_DEMUX_STATS_EN
    checkOutput("rst_stat_a", stat_a, 0);
    checkOutput("rst_stat_b", stat_b, 0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("release_ready_low", in_ready, 0);
    tick();
    checkOutput("release_ready_high", in_ready, 1);

    // Routing
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF);
    checkOutput("route_a_ready", in_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h12345678);
    checkOutput("route_a_valid", out_a_valid, 1);
    checkOutput("route_a_data", out_a_data, 32'hDEADBEEF);
    checkOutput("route_a_b_idle", out_b_valid, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("route_b_valid", out_b_valid, 1);
    checkOutput("route_b_data", out_b_data, 32'h12345678);
    checkOutput("route_b_a_idle", out_a_valid, 0);
    tick();
    checkOutput("route_b_drained", out_b_valid, 0);

    // Backpressure on A, B still flowing
    out_a_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'd2);
    checkOutput("bp_ready_w2", in_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'd3);
    checkOutput("bp_ready_w3", in_ready, 0);
    tick();
    checkOutput("bp_hold_ready", in_ready, 0);
    checkOutput("bp_head", out_a_data, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h55);
    checkOutput("bp_b_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("bp_b_data", out_b_data, 32'h55);
    checkOutput("bp_b_valid", out_b_valid, 1);
    tick();
    out_a_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'd3);
    checkOutput("bp_no_bypass", in_ready, 0);
    checkOutput("bp_out1", out_a_data, 32'd1);
    tick();
    checkOutput("bp_ready_after_pop", in_ready, 1);
    checkOutput("bp_out2", out_a_data, 32'd2);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("bp_out3", out_a_data, 32'd3);
    checkOutput("bp_out3_valid", out_a_valid, 1);
    tick();
    checkOutput("bp_drained", out_a_valid, 0);

    // Simultaneous push/pop at count 1
    out_a_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'd100);
    tick();
    out_a_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b1, 32'd100 + 32'(i));
      checkOutput("pp_ready", in_ready, 1);
      checkOutput("pp_valid", out_a_valid, 1);
      checkOutput("pp_data", out_a_data, 32'd100 + 32'(i - 1));
      tick();
    end
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("pp_last", out_a_data, 32'd110);
    tick();
    checkOutput("pp_drained", out_a_valid, 0);

    // Reset mid-stream with A holding two words
    out_a_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'hA1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'hA2);
    tick();
    checkOutput("mid_full", in_ready, 0);
    checkOutput("mid_head", out_a_data, 32'hA1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", out_a_valid, 0);
    checkOutput("mid_rst_ready", in_ready, 0);
    checkOutput("mid_rst_data", out_a_data, 0);
    tick();
    rst = 1'b0;
    out_a_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0);
    tick();
    checkOutput("mid_release_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mid_no_stale", out_a_valid, 0);
      tick();
    end

`ifdef PIPE_DEMUX_STATS_EN
    // 65534 streamed deliveries then three single ones to cross the wrap
    applyStimulus(1'b1, 1'b1, 32'h7);
    for (int i = 0; i < 65534; i++) tick();
    applyStimulus(1'b0, 1'b1, 32'h0);
    tick();
    checkOutput("stat_a_fffe", stat_a, 32'hFFFE);
    checkOutput("stat_b_hold0", stat_b, 0);
    begin
      logic [15:0] expStat [3];
      expStat[0] = 16'hFFFF;
      expStat[1] = 16'h0000;
      expStat[2] = 16'h0001;
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1'b1, 1'b1, 32'h9);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("stat_a_wrap", stat_a, {16'h0, expStat[i]});
      end
    end
    checkOutput("stat_b_hold1", stat_b, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
